// File: rtl/nes_pkg.sv
`default_nettype none
// ============================================================================
// Module   : nes_pkg
// Purpose  : Shared NES core definitions: CPU RAM geometry, sprite-DMA
//            register address, open-bus fill value and DMA state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package nes_pkg;

  localparam int          CPU_RAM_AW      = 11;        // 2 KB work RAM
  localparam logic [15:0] OAM_DMA_REG     = 16'h4014;  // decoded in the CPU bus decoder
  localparam logic [7:0]  OAM_DMA_OPENBUS = 8'hFF;     // data seen for pages outside RAM

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HALT  = 3'd1,
    ST_ALIGN = 3'd2,
    ST_READ  = 3'd3,
    ST_WRITE = 3'd4
  } oam_dma_state_t;

endpackage
`default_nettype wire

// File: rtl/oam_dma_if.sv
`default_nettype none
// ============================================================================
// Module   : oam_dma_if
// Purpose  : Memory-side bundle of the sprite DMA: CPU work-RAM read port
//            (DMA is master) and the PPU OAM byte-write port.
// Revision : 1.0 - initial release
// ============================================================================
interface oam_dma_if
  import nes_pkg::*;
#(
  parameter int RAM_AW = CPU_RAM_AW
) ();

  logic [RAM_AW-1:0] ram_address;
  logic              ram_write_enable;
  logic [7:0]        ram_read_data;
  logic              oam_wr_en;
  logic [7:0]        oam_addr;
  logic [7:0]        oam_wr_data;

  modport master (
    output ram_address, ram_write_enable, oam_wr_en, oam_addr, oam_wr_data,
    input  ram_read_data
  );

  modport slave (
    input  ram_address, ram_write_enable, oam_wr_en, oam_addr, oam_wr_data,
    output ram_read_data
  );

endinterface
`default_nettype wire

// File: rtl/oam_dma.sv
`default_nettype none
// ============================================================================
// Module   : oam_dma
// Purpose  : Sprite-DMA initiator. A $4014 write stalls the CPU and copies
//            one 256-byte page of CPU work RAM into PPU OAM, one byte every
//            two CPU cycles (READ then WRITE).
// Config   : OAM_DMA_ALIGN_EN - when defined, a get/put cycle-parity flop
//            and the ALIGN state are built so reads land on get cycles
//            (513 or 514 halt cycles). Undefined: fixed 513 halt cycles.
// Revision : 1.0 - initial release
// ============================================================================
module oam_dma
  import nes_pkg::*;
#(
  parameter int RAM_AW = CPU_RAM_AW
) (
  input  wire logic       clk,
  input  wire logic       rst_n,
  input  wire logic       dma_start,
  input  wire logic [7:0] dma_page,
  input  wire logic [7:0] oam_start,
  output logic            cpu_halt,
  output logic            busy,
  oam_dma_if.master       bus
);

  oam_dma_state_t r_state;
  oam_dma_state_t w_state_next;
  logic [7:0]     r_page;
  logic [7:0]     r_oam_base;
  logic [7:0]     r_index;
  logic           w_openbus;
  logic           w_accept;

  // Strobes arriving mid-transfer are ignored entirely.
  assign w_accept  = (r_state == ST_IDLE) && dma_start;
  // Only pages $00-$1F map onto (mirrored) work RAM.
  assign w_openbus = (r_page > 8'h1F);

`ifdef OAM_DMA_ALIGN_EN
  logic r_parity;

  // Free-running get(0)/put(1) cycle parity.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_parity <= 1'b0;
    else        r_parity <= ~r_parity;
  end
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  // Transfer context: latched on an accepted strobe, index steps after each WRITE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_page     <= 8'h00;
      r_oam_base <= 8'h00;
      r_index    <= 8'h00;
    end else if (w_accept) begin
      r_page     <= dma_page;
      r_oam_base <= oam_start;
      r_index    <= 8'h00;
    end else if (r_state == ST_WRITE) begin
      r_index    <= r_index + 8'd1;
    end
  end

  // Next-state decode and state-decoded bus outputs.
  always_comb begin
    w_state_next    = r_state;
    bus.ram_address = '0;
    bus.oam_wr_en   = 1'b0;
    bus.oam_addr    = 8'h00;
    bus.oam_wr_data = 8'h00;
    unique case (r_state)
      ST_IDLE: begin
        if (dma_start) w_state_next = ST_HALT;
      end
      ST_HALT: begin
`ifdef OAM_DMA_ALIGN_EN
        // Current cycle even means the next one is a put: burn it in ALIGN.
        w_state_next = r_parity ? ST_READ : ST_ALIGN;
`else
        w_state_next = ST_READ;
`endif
      end
      ST_ALIGN: begin
        w_state_next = ST_READ;
      end
      ST_READ: begin
        bus.ram_address = w_openbus ? '0 : RAM_AW'({r_page, r_index});
        w_state_next    = ST_WRITE;
      end
      ST_WRITE: begin
        bus.oam_wr_en   = 1'b1;
        bus.oam_addr    = r_oam_base + r_index;
        bus.oam_wr_data = w_openbus ? OAM_DMA_OPENBUS : bus.ram_read_data;
        w_state_next    = (r_index == 8'hFF) ? ST_IDLE : ST_READ;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  assign cpu_halt             = (r_state != ST_IDLE);
  assign busy                 = (r_state != ST_IDLE);
  assign bus.ram_write_enable = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_oam_dma.sv
`default_nettype none
// ============================================================================
// Module   : tb_oam_dma
// Purpose  : Self-checking bench for oam_dma. Random RAM contents and
//            transfer parameters; expected OAM image, halt length and write
//            latency come from a page-copy reference model.
// Config   : follows OAM_DMA_ALIGN_EN like the design.
// Revision : 1.0 - initial release
// ============================================================================
module tb_oam_dma;
  import nes_pkg::*;

`ifdef OAM_DMA_ALIGN_EN
  localparam bit c_align_en = 1'b1;
`else
  localparam bit c_align_en = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       dma_start = 1'b0;
  logic [7:0] dma_page = 8'h00;
  logic [7:0] oam_start = 8'h00;
  logic       cpu_halt;
  logic       busy;

  oam_dma_if #(.RAM_AW(CPU_RAM_AW)) bus ();

  oam_dma #(.RAM_AW(CPU_RAM_AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .dma_start (dma_start),
    .dma_page  (dma_page),
    .oam_start (oam_start),
    .cpu_halt  (cpu_halt),
    .busy      (busy),
    .bus       (bus.master)
  );

  always #5 clk = ~clk;

  logic [7:0] ram     [0:2047];
  logic [7:0] oam_mem [0:255];
  logic [7:0] oam_exp [0:255];

  // Registered-read work RAM: one cycle of latency.
  always @(posedge clk) bus.ram_read_data <= ram[bus.ram_address];

  // Cycle number since reset release; its LSB is the get/put parity.
  int unsigned cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Runs one transfer. Called and returns on a negedge. want_par: 0/1 waits
  // for that strobe-cycle parity, 2 strobes immediately. inject_at/reset_at:
  // cycle after the strobe at which to fire a stray strobe / assert reset.
  task automatic do_dma(input logic [7:0] page, input logic [7:0] start,
                        input int want_par, input int inject_at, input int reset_at);
    int unsigned strobe_cyc = 0, first_halt = 0, first_wr = 0;
    int          halt_cnt = 0, wr_cnt = 0, k = 0;
    int          bad_addr = 0, bad_seq = 0, we_cnt = 0, mism = 0;
    int          base;
    bit          seen_halt = 0, got_wr = 0, aligned;

    if (want_par != 2 && int'(cyc % 2) != want_par) @(negedge clk);

    // Reference: byte i of the page (RAM mirrored every 2 KB, or open bus)
    // lands at OAM (start + i) mod 256.
    base = (int'(page) * 256) % 2048;
    for (int i = 0; i < 256; i++)
      oam_exp[(int'(start) + i) % 256] = (page < 8'h20) ? ram[base + i] : OAM_DMA_OPENBUS;

    dma_start  = 1'b1;
    dma_page   = page;
    oam_start  = start;
    strobe_cyc = cyc;
    aligned    = c_align_en && (strobe_cyc % 2 == 1);

    while (1) begin
      @(negedge clk);
      k++;
      if (bus.ram_write_enable) we_cnt++;
      if (cpu_halt) begin
        if (!seen_halt) first_halt = cyc;
        seen_halt = 1;
        halt_cnt++;
      end else if (seen_halt) begin
        break;
      end
      if (bus.ram_address != 0) begin
        if (page >= 8'h20 || int'(bus.ram_address) < base || int'(bus.ram_address) > base + 255)
          bad_addr++;
      end
      if (bus.oam_wr_en) begin
        if (!got_wr) first_wr = cyc;
        got_wr = 1;
        if (int'(bus.oam_addr) != (int'(start) + wr_cnt) % 256) bad_seq++;
        oam_mem[bus.oam_addr] = bus.oam_wr_data;
        wr_cnt++;
      end
      if (k == 1) dma_start = 1'b0;
      if (inject_at != 0 && k == inject_at) begin
        dma_start = 1'b1;
        dma_page  = 8'h07;
        oam_start = 8'h33;
      end
      if (inject_at != 0 && k == inject_at + 1) dma_start = 1'b0;
      if (reset_at != 0 && k == reset_at) begin
        rst_n = 1'b0;
        #1;
        check("rst_cpu_halt", cpu_halt, 0);
        check("rst_busy", busy, 0);
        check("rst_oam_wr_en", bus.oam_wr_en, 0);
        check("rst_ram_address", bus.ram_address, 0);
        repeat (3) begin
          @(negedge clk);
          if (bus.oam_wr_en) wr_cnt = 1000;
        end
        check("rst_partial_writes", (wr_cnt > 0 && wr_cnt < 256), 1);
        rst_n = 1'b1;
        @(negedge clk);
        return;
      end
      if (k > 700) begin
        check("timeout", k, 700);
        break;
      end
    end

    for (int i = 0; i < 256; i++)
      if (oam_mem[i] !== oam_exp[i]) mism++;

    check("halt_start", first_halt - strobe_cyc, 1);
    check("halt_len", halt_cnt, aligned ? 514 : 513);
    check("first_wr", first_wr - strobe_cyc, aligned ? 4 : 3);
    check("wr_count", wr_cnt, 256);
    check("oam_addr_seq", bad_seq, 0);
    check("ram_address_range", bad_addr, 0);
    check("ram_we", we_cnt, 0);
    check("oam_data", mism, 0);
    check("busy_end", busy, 0);
  endtask

  initial begin
    for (int a = 0; a < 2048; a++) ram[a] = 8'($urandom);
    for (int i = 0; i < 256; i++) oam_mem[i] = 8'h00;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_cpu_halt", cpu_halt, 0);
    check("reset_busy", busy, 0);
    check("reset_ram_address", bus.ram_address, 0);
    check("reset_ram_we", bus.ram_write_enable, 0);
    check("reset_oam_wr_en", bus.oam_wr_en, 0);
    check("reset_oam_addr", bus.oam_addr, 0);
    check("reset_oam_wr_data", bus.oam_wr_data, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 256; i++) ram[512 + i] = 8'(i) ^ 8'h5A;

    do_dma(8'h02, 8'h00, 0, 0, 0);     // even strobe
    do_dma(8'h02, 8'h00, 1, 0, 0);     // odd strobe
    do_dma(8'h0A, 8'hF0, 2, 0, 0);     // back-to-back, mirror, OAM wrap
    do_dma(8'h40, 8'h10, 0, 0, 0);     // open bus page
    do_dma(8'h05, 8'h80, 1, 100, 0);   // stray strobe mid-transfer
    do_dma(8'h1F, 8'h00, 0, 0, 300);   // reset mid-transfer
    do_dma(8'h03, 8'h77, 0, 0, 0);     // recovery after reset
    repeat (4) do_dma(8'($urandom), 8'($urandom), int'($urandom_range(0, 1)), 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
